// File: rtl/handshake_responder.sv
// handshake_responder: debounces the raw push-button into the picoMips Handshake level and
// freezes the slide switches on every debounced press so the core reads stable operands.
module handshake_responder #(
    parameter int DATA_W          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Button,
    input  logic [DATA_W-1:0] SW,
    input  logic              PCHold,
    output logic              Handshake,
    output logic [DATA_W-1:0] SwData,
    output logic              Strobe,
    output logic              Waiting,
    output logic [7:0]        PressCount
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_SETTLED  = 1'b0;
    localparam logic [0:0] ST_DEBOUNCE = 1'b1;

    logic [SYNC_STAGES-1:0] btn_sync_r;
    logic [DATA_W-1:0]      sw_sync_r [SYNC_STAGES];
    logic                   btn_s;
    logic [DATA_W-1:0]      sw_s;
    logic [0:0]             state_r;
    logic [0:0]             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   toggle_s;

    assign btn_s = btn_sync_r[SYNC_STAGES-1];
    assign sw_s  = sw_sync_r[SYNC_STAGES-1];

    // Input synchronisers: the only logic that touches the raw board inputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            btn_sync_r <= {SYNC_STAGES{1'b0}};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            btn_sync_r[0] <= Button;
            sw_sync_r[0]  <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                btn_sync_r[i] <= btn_sync_r[i-1];
                sw_sync_r[i]  <= sw_sync_r[i-1];
            end
        end
    end

    // Debounce next-state: any return to the current level abandons the pending change.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        toggle_s    = 1'b0;
        case (state_r)
            ST_SETTLED: begin
                if (btn_s != Handshake) begin
                    state_nxt_s = ST_DEBOUNCE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_SETTLED;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_DEBOUNCE: begin
                if (btn_s == Handshake) begin
                    state_nxt_s = ST_SETTLED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_SETTLED;
                    cnt_nxt_s   = CNT_ZERO;
                    toggle_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_DEBOUNCE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_SETTLED;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_SETTLED;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered outputs; switch capture and press count advance only on a rising Handshake.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Handshake  <= 1'b0;
            SwData     <= {DATA_W{1'b0}};
            Strobe     <= 1'b0;
            Waiting    <= 1'b0;
            PressCount <= 8'h00;
        end else begin
            Strobe  <= toggle_s;
            Waiting <= PCHold;
            if (toggle_s) begin
                Handshake <= ~Handshake;
                if (!Handshake) begin
                    SwData     <= sw_s;
                    PressCount <= PressCount + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_responder.sv
// tb_handshake_responder: vector table, hand-written corner sequences and random stimulus,
// all checked against a sample-history reference model of the responder.
module tb_handshake_responder;
    localparam int DATA_W          = 8;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic              Clock = 1'b0;
    logic              nReset;
    logic              Button;
    logic [DATA_W-1:0] SW;
    logic              PCHold;
    logic              Handshake;
    logic [DATA_W-1:0] SwData;
    logic              Strobe;
    logic              Waiting;
    logic [7:0]        PressCount;

    handshake_responder #(
        .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .Clock(Clock), .nReset(nReset), .Button(Button), .SW(SW), .PCHold(PCHold),
        .Handshake(Handshake), .SwData(SwData), .Strobe(Strobe), .Waiting(Waiting),
        .PressCount(PressCount)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // Reference model: raw input history, synchronised-button window, expected outputs.
    bit         btn_raw_q[$];
    logic [7:0] sw_raw_q[$];
    bit         seen_q[$];
    bit         m_hs;
    logic [7:0] m_sw;
    bit         m_strobe;
    bit         m_wait;
    logic [7:0] m_cnt;

    typedef struct {
        bit         button;
        logic [7:0] sw;
        int         cycles;
        bit         exp_hs;
        logic [7:0] exp_sw;
        logic [7:0] exp_cnt;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        btn_raw_q.delete();
        sw_raw_q.delete();
        seen_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) begin
            btn_raw_q.push_back(1'b0);
            sw_raw_q.push_back(8'h00);
        end
        for (int i = 0; i <= DEBOUNCE_CYCLES; i++) seen_q.push_back(1'b0);
        m_hs = 1'b0; m_sw = 8'h00; m_strobe = 1'b0; m_wait = 1'b0; m_cnt = 8'h00;
    endtask

    // A level is accepted once the last DEBOUNCE_CYCLES+1 synchronised samples all differ from it.
    task automatic model_edge();
        bit         btn_seen;
        logic [7:0] sw_seen;
        bit         all_diff;
        btn_seen = btn_raw_q.pop_front();
        sw_seen  = sw_raw_q.pop_front();
        btn_raw_q.push_back(Button);
        sw_raw_q.push_back(SW);
        void'(seen_q.pop_front());
        seen_q.push_back(btn_seen);
        all_diff = 1'b1;
        foreach (seen_q[i]) if (seen_q[i] == m_hs) all_diff = 1'b0;
        m_strobe = all_diff;
        m_wait   = PCHold;
        if (all_diff) begin
            m_hs = ~m_hs;
            if (m_hs) begin
                m_sw  = sw_seen;
                m_cnt = m_cnt + 8'd1;
            end
        end
    endtask

    task automatic step(input string name);
        @(posedge Clock);
        model_edge();
        #1;
        check(name, {Handshake, Strobe, Waiting, SwData, PressCount},
              {m_hs, m_strobe, m_wait, m_sw, m_cnt});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: {button, sw, cycles, expected Handshake, SwData, PressCount} at end of each row.
        vecs[0]  = '{1'b1, 8'h11, 10, 1'b1, 8'hA5, 8'd1};
        vecs[1]  = '{1'b0, 8'h3C, 10, 1'b0, 8'hA5, 8'd1};
        vecs[2]  = '{1'b1, 8'h3C,  3, 1'b0, 8'hA5, 8'd1};
        vecs[3]  = '{1'b0, 8'h77, 10, 1'b0, 8'hA5, 8'd1};
        vecs[4]  = '{1'b1, 8'h3C, 10, 1'b1, 8'h3C, 8'd2};
        vecs[5]  = '{1'b1, 8'hF0,  4, 1'b1, 8'h3C, 8'd2};
        vecs[6]  = '{1'b0, 8'hF0,  5, 1'b1, 8'h3C, 8'd2};
        vecs[7]  = '{1'b0, 8'hF0,  5, 1'b0, 8'h3C, 8'd2};
        vecs[8]  = '{1'b1, 8'h5A,  4, 1'b0, 8'h3C, 8'd2};
        vecs[9]  = '{1'b0, 8'h5A,  8, 1'b0, 8'h3C, 8'd2};
        vecs[10] = '{1'b1, 8'h5A,  5, 1'b0, 8'h3C, 8'd2};
        vecs[11] = '{1'b0, 8'h5A,  8, 1'b0, 8'h5A, 8'd3};

        // Reset, then idle with switches wiggling.
        nReset = 1'b0; Button = 1'b0; SW = 8'h00; PCHold = 1'b0;
        #12;
        check("reset_state", {Handshake, Strobe, Waiting, SwData, PressCount}, 32'd0);
        model_reset();
        @(negedge Clock);
        nReset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            SW = 8'($urandom);
            step("idle");
            check("idle_zero", {Handshake, Strobe, SwData, PressCount}, 32'd0);
        end

        // First press: exact toggle edge, single-cycle strobe.
        SW = 8'hA5; Button = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step("press_a5");
            check("lat_hs", 32'(Handshake), (i >= 7) ? 32'd1 : 32'd0);
            check("lat_strobe", 32'(Strobe), (i == 7) ? 32'd1 : 32'd0);
        end
        check("press_a5_data", {SwData, PressCount}, {8'hA5, 8'd1});

        for (int v = 0; v < 12; v++) begin
            Button = vecs[v].button;
            SW     = vecs[v].sw;
            for (int c = 0; c < vecs[v].cycles; c++) step("vec_cycle");
            check($sformatf("vec%0d", v), {Handshake, SwData, PressCount},
                  {vecs[v].exp_hs, vecs[v].exp_sw, vecs[v].exp_cnt});
        end

        // Reset in DEBOUNCE with cnt=2, then the still-held button is re-accepted.
        Button = 1'b1; SW = 8'h81;
        for (int i = 0; i < 5; i++) step("pre_rst");
        nReset = 1'b0;
        #1;
        check("async_rst", {Handshake, Strobe, Waiting, SwData, PressCount}, 32'd0);
        model_reset();
        SW = 8'hC3;
        #1;
        nReset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step("post_rst");
            check("post_rst_hs", 32'(Handshake), (i == 7) ? 32'd1 : 32'd0);
        end
        check("post_rst_data", {SwData, PressCount}, {8'hC3, 8'd1});
        Button = 1'b0;
        for (int i = 0; i < 8; i++) step("post_rst_rel");

        // 256 clean presses with PCHold toggling: count wraps back to its start value.
        for (int p = 0; p < 256; p++) begin
            Button = 1'b1;
            for (int i = 0; i < 7; i++) begin
                PCHold = ~PCHold; SW = 8'(p);
                step("wrap_press");
            end
            Button = 1'b0;
            for (int i = 0; i < 7; i++) begin
                PCHold = ~PCHold;
                step("wrap_release");
            end
        end
        check("wrap_count", {Handshake, SwData, PressCount}, {1'b0, 8'hFF, 8'd1});

        // Random bouncy button, switches and PCHold.
        begin
            int run;
            run = 0;
            for (int n = 0; n < 3000; n++) begin
                if (run == 0) begin
                    Button = ~Button;
                    run = int'($urandom_range(1, 9));
                end
                run--;
                SW     = 8'($urandom);
                PCHold = 1'($urandom);
                step("random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
